// File: rtl/cu_state_sequencer.sv
// Multicycle RISC-V control-unit next-state sequencer with state register, retire counter and illegal-opcode flag.
// Latency: state advances one step per unstalled clk edge; InstrDone is combinational from the current state.
// Backpressure: Stall=1 freezes state, counter and flag (ClrIllegal still honoured) and masks InstrDone.
module cu_state_sequencer #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           Opcode,
   input  logic                 Stall,
   input  logic                 ClrIllegal,
   output logic [3:0]           StateRegister,
   output logic                 InstrDone,
   output logic                 IllegalOp,
   output logic [CNT_WIDTH-1:0] InstrCount
);

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADDR  = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_LOADWB   = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECUTE  = 4'd6,
      ST_RWB      = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_JUMP     = 4'd9
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // Kept as a plain vector so encodings 10-15 are representable and recover to Fetch.
   logic [3:0]           state_q;
   logic [3:0]           state_d;
   logic                 illegal_q;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 set_illegal;
   logic                 terminal;

   // Next-state function of the current state and the held opcode only.
   always_comb begin
      state_d     = ST_FETCH;
      set_illegal = 1'b0;
      case (state_q)
         ST_FETCH:   state_d = ST_DECODE;
         ST_DECODE: begin
            case (Opcode)
               OP_LOAD,
               OP_STORE:  state_d = ST_MEMADDR;
               OP_RTYPE:  state_d = ST_EXECUTE;
               OP_BRANCH: state_d = ST_BRANCH;
               OP_JAL:    state_d = ST_JUMP;
               default: begin
                  state_d     = ST_FETCH;
                  set_illegal = 1'b1;
               end
            endcase
         end
         ST_MEMADDR: begin
            // Anything but LOAD/STORE here means the IR changed under us.
            case (Opcode)
               OP_LOAD:  state_d = ST_MEMREAD;
               OP_STORE: state_d = ST_MEMWRITE;
               default: begin
                  state_d     = ST_FETCH;
                  set_illegal = 1'b1;
               end
            endcase
         end
         ST_MEMREAD: state_d = ST_LOADWB;
         ST_EXECUTE: state_d = ST_RWB;
         // Terminal states and unreachable encodings all return to Fetch.
         default:    state_d = ST_FETCH;
      endcase
   end

   // Terminal-state decode; completion is only reported on an unstalled cycle.
   always_comb begin
      terminal = (state_q == ST_LOADWB)  || (state_q == ST_MEMWRITE) ||
                 (state_q == ST_RWB)     || (state_q == ST_BRANCH)   ||
                 (state_q == ST_JUMP);
      InstrDone = terminal && !Stall;
   end

   // State register, retire counter and sticky illegal flag; a set beats a same-edge clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         if (!Stall) begin
            state_q <= state_d;
            if (terminal) begin
               count_q <= count_q + CNT_ONE;
            end
         end
         if (!Stall && set_illegal) begin
            illegal_q <= 1'b1;
         end else if (ClrIllegal) begin
            illegal_q <= 1'b0;
         end
      end
   end

   assign StateRegister = state_q;
   assign IllegalOp     = illegal_q;
   assign InstrCount    = count_q;

endmodule

// File: tb/tb_cu_state_sequencer.sv
module tb_cu_state_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] Opcode = 7'h00;
   logic       Stall = 1'b0;
   logic       ClrIllegal = 1'b0;
   logic [3:0] StateRegister;
   logic       InstrDone;
   logic       IllegalOp;
   logic [3:0] InstrCount;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0] st;
      logic       dn;
      logic       il;
      logic [3:0] cn;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   cu_state_sequencer #(.CNT_WIDTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Opcode       (Opcode),
      .Stall        (Stall),
      .ClrIllegal   (ClrIllegal),
      .StateRegister(StateRegister),
      .InstrDone    (InstrDone),
      .IllegalOp    (IllegalOp),
      .InstrCount   (InstrCount)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // Monitor: one expected vector per cycle, compared on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         tests++;
         if (StateRegister !== e.st || InstrDone !== e.dn ||
             IllegalOp !== e.il || InstrCount !== e.cn) begin
            fails++;
            $display("FAIL %s: got st=%0d done=%0b ill=%0b cnt=%0d, want st=%0d done=%0b ill=%0b cnt=%0d",
                     e.tag, StateRegister, InstrDone, IllegalOp, InstrCount,
                     e.st, e.dn, e.il, e.cn);
         end
      end
   end

   task automatic push_exp(input logic [3:0] st, input logic dn, input logic il,
                           input logic [3:0] cn, input string tag);
      exp_t e;
      e.st = st; e.dn = dn; e.il = il; e.cn = cn; e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1: apply inputs for this cycle, queue its expected outputs, advance.
   task automatic step(input logic [6:0] op, input logic stl, input logic clr,
                       input logic [3:0] st, input logic dn, input logic il,
                       input logic [3:0] cn, input string tag);
      Opcode = op; Stall = stl; ClrIllegal = clr;
      push_exp(st, dn, il, cn, tag);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; Opcode = 7'h00; Stall = 1'b0; ClrIllegal = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_state", int'(StateRegister), 0);
      chk("rst_done",  int'(InstrDone), 0);
      chk("rst_ill",   int'(IllegalOp), 0);
      chk("rst_cnt",   int'(InstrCount), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // LOAD: 0,1,2,3,4 then count 1
      step(7'h03, 0, 0, 0, 0, 0, 0, "ld_s0");
      step(7'h03, 0, 0, 1, 0, 0, 0, "ld_s1");
      step(7'h03, 0, 0, 2, 0, 0, 0, "ld_s2");
      step(7'h03, 0, 0, 3, 0, 0, 0, "ld_s3");
      step(7'h03, 0, 0, 4, 1, 0, 0, "ld_s4");
      // STORE, RTYPE, BRANCH, JAL back to back
      step(7'h23, 0, 0, 0, 0, 0, 1, "st_s0");
      step(7'h23, 0, 0, 1, 0, 0, 1, "st_s1");
      step(7'h23, 0, 0, 2, 0, 0, 1, "st_s2");
      step(7'h23, 0, 0, 5, 1, 0, 1, "st_s5");
      step(7'h33, 0, 0, 0, 0, 0, 2, "rt_s0");
      step(7'h33, 0, 0, 1, 0, 0, 2, "rt_s1");
      step(7'h33, 0, 0, 6, 0, 0, 2, "rt_s6");
      step(7'h33, 0, 0, 7, 1, 0, 2, "rt_s7");
      step(7'h63, 0, 0, 0, 0, 0, 3, "br_s0");
      step(7'h63, 0, 0, 1, 0, 0, 3, "br_s1");
      step(7'h63, 0, 0, 8, 1, 0, 3, "br_s8");
      step(7'h6F, 0, 0, 0, 0, 0, 4, "jal_s0");
      step(7'h6F, 0, 0, 1, 0, 0, 4, "jal_s1");
      step(7'h6F, 0, 0, 9, 1, 0, 4, "jal_s9");
      // Illegal opcode, clear alone, then clear on the setting edge
      step(7'h13, 0, 0, 0, 0, 0, 5, "ill_s0");
      step(7'h13, 0, 0, 1, 0, 0, 5, "ill_s1");
      step(7'h13, 0, 1, 0, 0, 1, 5, "ill_set_clr");
      step(7'h13, 0, 1, 1, 0, 0, 5, "ill_cleared");
      // LOAD with 3 stall cycles in state 3; clear honoured mid-stall
      step(7'h03, 0, 0, 0, 0, 1, 5, "ill_set_wins");
      step(7'h03, 0, 0, 1, 0, 1, 5, "sld_s1");
      step(7'h03, 0, 0, 2, 0, 1, 5, "sld_s2");
      step(7'h03, 1, 0, 3, 0, 1, 5, "sld_stall1");
      step(7'h03, 1, 1, 3, 0, 1, 5, "sld_stall2");
      step(7'h03, 1, 0, 3, 0, 0, 5, "sld_stall3");
      step(7'h03, 0, 0, 3, 0, 0, 5, "sld_s3");
      step(7'h03, 0, 0, 4, 1, 0, 5, "sld_s4");
      step(7'h03, 0, 0, 0, 0, 0, 6, "sld_done");

      // 17 RTYPE from a clean reset, 4-bit counter wraps 15 -> 0 -> 1
      do_reset();
      for (int k = 0; k < 17; k++) begin
         logic [3:0] c;
         c = 4'(k);
         step(7'h33, 0, 0, 0, 0, 0, c, "wr_s0");
         step(7'h33, 0, 0, 1, 0, 0, c, "wr_s1");
         step(7'h33, 0, 0, 6, 0, 0, c, "wr_s6");
         if (k == 5) step(7'h33, 1, 0, 7, 0, 0, c, "wr_s7_stalled");
         step(7'h33, 0, 0, 7, 1, 0, c, "wr_s7");
      end
      step(7'h13, 0, 0, 0, 0, 0, 1, "wr_end");
      step(7'h13, 0, 0, 1, 0, 0, 1, "ar_ill_s1");
      step(7'h33, 0, 0, 0, 0, 1, 1, "ar_s0");
      step(7'h33, 0, 0, 1, 0, 1, 1, "ar_s1");
      // State 6, then asynchronous reset between edges
      Opcode = 7'h33;
      push_exp(6, 0, 1, 1, "ar_s6");
      #5;
      rst_n = 1'b0;
      #1;
      chk("async_state", int'(StateRegister), 0);
      chk("async_cnt",   int'(InstrCount), 0);
      chk("async_ill",   int'(IllegalOp), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // JAL, then IR corruption in MemAddr, then forced unreachable state
      step(7'h6F, 0, 0, 0, 0, 0, 0, "fc_jal_s0");
      step(7'h6F, 0, 0, 1, 0, 0, 0, "fc_jal_s1");
      step(7'h6F, 0, 0, 9, 1, 0, 0, "fc_jal_s9");
      step(7'h03, 0, 0, 0, 0, 0, 1, "ir_s0");
      step(7'h03, 0, 0, 1, 0, 0, 1, "ir_s1");
      step(7'h33, 0, 0, 2, 0, 0, 1, "ir_s2_corrupt");
      Opcode = 7'h03;
      push_exp(0, 0, 1, 1, "ir_back_s0");
      #5;
      force dut.state_q = 4'd12;
      #1;
      release dut.state_q;
      #1;
      chk("forced_state", int'(StateRegister), 12);
      chk("forced_done",  int'(InstrDone), 0);
      @(posedge clk);
      #1;
      step(7'h03, 0, 0, 0, 0, 1, 1, "from12_s0");
      step(7'h03, 0, 0, 1, 0, 1, 1, "from12_s1");

      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
